resource_arbiter: RTL and testbench
===================================

Name: resource_arbiter

Overview:
- Arbitrates spend and refill transactions from N requesters onto three shared resource pools: energy (8-bit), spider-tracer (6-bit) and fluid (4-bit).
- Owns the pool registers and sequences one transaction at a time through a single add/subtract path.
- Grants requesters round-robin. Spends are all-or-nothing; refills saturate at the pool maximum.
- Sits between the suit subsystems (requesters) and the resource datapath.

Parameters:
- N, 3, number of requesters (2..8).
- ENERGY_RST, 8'd255, energy pool reset value.
- TRACER_RST, 6'd63, tracer pool reset value.
- FLUID_RST, 4'd15, fluid pool reset value.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req  in  N  per-requester request level. Held until that requester's ack.
- req_op  in  N  per-requester op: 0 = spend, 1 = refill.
- req_sel  in  2N  per-requester pool select, bits [2i+1:2i]: 0 = energy, 1 = tracer, 2 = fluid, 3 = invalid.
- req_amt  in  8N  per-requester amount, bits [8i+7:8i], unsigned.
- ack  out  N  one-hot, one-cycle completion pulse to the served requester.
- ok  out  1  valid with ack: transaction applied.
- sat  out  1  valid with ack: refill clipped at the pool maximum.
- busy  out  1  high whenever the FSM is not in IDLE.
- energy  out  8  energy pool level.
- tracer  out  6  tracer pool level.
- fluid  out  4  fluid pool level.

Behaviour:
Reset:
- State = IDLE; round-robin pointer = 0.
- ack = 0, ok = 0, sat = 0, busy = 0.
- energy = ENERGY_RST, tracer = TRACER_RST, fluid = FLUID_RST.
- Reset mid-transaction aborts it: no pool update, no ack.

FSM states: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - If any req is high, pick the winner: first requester with req high, searching upward from the pointer and wrapping modulo N.
  - Latch the winner index, op, sel and amt. Go to EXEC.
  - Inputs are never sampled outside IDLE; changes during EXEC/RESP are ignored.
- EXEC (one cycle):
  - Compute on the latched values.
  - Registered ok/sat and the pool write take effect at the end of this cycle.
  - Go to RESP.
- RESP (one cycle):
  - ack[winner] = 1, with ok and sat valid.
  - Pointer = (winner + 1) mod N. Go to IDLE.
  - ack, ok and sat are 0 in every other state.

Latency and throughput:
- req seen in IDLE at cycle t -> pool updated and ack high at cycle t+2.
- Back-to-back throughput: one transaction per 3 cycles.

Requester rule:
- Deassert req, or present a new transaction, in the cycle after ack.
- A req still high in IDLE is treated as a new transaction.

Arithmetic:
- All compares use the 9-bit zero-extended pool level L and amount A. Pool max M = 255, 63 or 15.
- Spend, A <= L: L -= A, ok = 1.
- Spend, A > L: no change, ok = 0. All-or-nothing; no partial spend.
- Refill, L + A <= M: L += A, ok = 1, sat = 0.
- Refill, L + A > M: L = M, ok = 1, sat = 1.
- A = 0: ok = 1, no change, sat = 0.
- sel = 3: ok = 0, sat = 0, no pool change. ack is still issued.

Other rules:
- Only the selected pool is written; the other two hold.
- Simultaneous requests: exactly one is granted per transaction. Each continuously requesting requester is served within N transactions, with no starvation.

Test Plan:
1. Reset, then idle 5 cycles -> energy = 255, tracer = 63, fluid = 15; ack = 0, busy = 0.
2. Req0 spends 100 energy -> ack[0] 2 cycles after req seen, ok = 1, energy = 155. Req0 spends 200 energy -> ok = 0, energy stays 155.
3. Req1 spends 60 tracer, then refills 10 -> tracer = 3, then 13, sat = 0. Refill 200 -> tracer = 63, ok = 1, sat = 1.
4. req = 3'b111 held continuously, each requester spending 1 fluid -> ack order 0, 1, 2, 0, 1, 2; fluid decrements 15 -> 9; ack every 3 cycles.
5. sel = 3 spend 5 -> ack, ok = 0, all pools unchanged. Spend amt 0 on energy -> ok = 1, energy unchanged.
6. Assert reset during EXEC of a spend of 50 energy -> no ack; energy = 255, pointer = 0, FSM in IDLE next cycle.

Source files
------------

// File: rtl/resource_arbiter.sv
// ---------------------------------------------------------------------------
// resource_arbiter
//   Serialises spend/refill transactions from N requesters onto three shared
//   resource pools (energy 8-bit, tracer 6-bit, fluid 4-bit). Requesters are
//   granted round-robin; one transaction at a time flows through a single
//   add/subtract path. Spends are all-or-nothing, refills saturate at the
//   pool maximum.
//
//   Sequence per transaction: IDLE (arbitrate + latch) -> EXEC (compute and
//   write pool, register ok/sat) -> RESP (ack pulse) -> IDLE.
//
// Ports
//   clk      in   clock
//   reset    in   synchronous, active-high reset
//   req      in   [N]    request level per requester, held until its ack
//   req_op   in   [N]    0 = spend, 1 = refill
//   req_sel  in   [2N]   pool select per requester: 0 energy, 1 tracer,
//                        2 fluid, 3 invalid
//   req_amt  in   [8N]   unsigned amount per requester
//   ack      out  [N]    one-hot, one-cycle completion pulse
//   ok       out         valid with ack: transaction applied
//   sat      out         valid with ack: refill clipped at pool maximum
//   busy     out         high whenever the FSM is not in IDLE
//   energy   out  [8]    energy pool level
//   tracer   out  [6]    tracer pool level
//   fluid    out  [4]    fluid pool level
// ---------------------------------------------------------------------------
module resource_arbiter #(
   parameter int         N          = 3,
   parameter logic [7:0] ENERGY_RST = 8'd255,
   parameter logic [5:0] TRACER_RST = 6'd63,
   parameter logic [3:0] FLUID_RST  = 4'd15
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [N-1:0]   req,
   input  logic [N-1:0]   req_op,
   input  logic [2*N-1:0] req_sel,
   input  logic [8*N-1:0] req_amt,
   output logic [N-1:0]   ack,
   output logic           ok,
   output logic           sat,
   output logic           busy,
   output logic [7:0]     energy,
   output logic [5:0]     tracer,
   output logic [3:0]     fluid
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   // First requester with req high, searching upward from p and wrapping.
   function automatic logic [PW-1:0] rr_pick(input logic [N-1:0] r,
                                              input logic [PW-1:0] p);
      logic [PW-1:0] w;
      logic          found;
      int            j;
      w     = '0;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
         j = (int'(p) + k) % N;
         if (!found && r[j]) begin
            found = 1'b1;
            w     = PW'(j);
         end
      end
      return w;
   endfunction

   // Returns {ok, sat, new_level}. All compares are 9-bit so that L + A
   // never wraps before the saturation test.
   function automatic logic [9:0] pool_apply(input logic       op,
                                             input logic [7:0] lvl,
                                             input logic [7:0] maxv,
                                             input logic [7:0] amt);
      logic [8:0] l9, a9, m9, sum9, diff9;
      logic [9:0] res;
      l9    = {1'b0, lvl};
      a9    = {1'b0, amt};
      m9    = {1'b0, maxv};
      sum9  = l9 + a9;
      diff9 = l9 - a9;
      if (!op) begin
         if (a9 <= l9) res = {1'b1, 1'b0, diff9[7:0]};
         else          res = {1'b0, 1'b0, lvl};
      end else begin
         if (sum9 > m9) res = {1'b1, 1'b1, maxv};
         else           res = {1'b1, 1'b0, sum9[7:0]};
      end
      return res;
   endfunction

   state_t        state_q;
   logic [PW-1:0] ptr_q;
   logic [PW-1:0] win_q;
   logic          op_q;
   logic [1:0]    sel_q;
   logic [7:0]    amt_q;
   logic [7:0]    energy_q;
   logic [5:0]    tracer_q;
   logic [3:0]    fluid_q;
   logic [N-1:0]  ack_q;
   logic          ok_q;
   logic          sat_q;
   logic          busy_q;

   logic [PW-1:0] win_d;
   logic [PW-1:0] ptr_d;
   logic [7:0]    cur_lvl;
   logic [7:0]    cur_max;
   logic [9:0]    apply_res;
   logic [7:0]    lvl_d;
   logic          ok_d;
   logic          sat_d;

   always_comb begin
      win_d   = rr_pick(req, ptr_q);
      ptr_d   = (win_q == PW'(N - 1)) ? '0 : win_q + 1'b1;
      cur_lvl = 8'd0;
      cur_max = 8'd0;
      case (sel_q)
         2'd0: begin
            cur_lvl = energy_q;
            cur_max = 8'd255;
         end
         2'd1: begin
            cur_lvl = {2'b00, tracer_q};
            cur_max = 8'd63;
         end
         2'd2: begin
            cur_lvl = {4'b0000, fluid_q};
            cur_max = 8'd15;
         end
         default: begin
            cur_lvl = 8'd0;
            cur_max = 8'd0;
         end
      endcase
      apply_res = pool_apply(op_q, cur_lvl, cur_max, amt_q);
      lvl_d     = apply_res[7:0];
      // An invalid pool select still completes, but reports nothing applied.
      ok_d      = (sel_q == 2'd3) ? 1'b0 : apply_res[9];
      sat_d     = (sel_q == 2'd3) ? 1'b0 : apply_res[8];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         ack_q    <= '0;
         ok_q     <= 1'b0;
         sat_q    <= 1'b0;
         busy_q   <= 1'b0;
         energy_q <= ENERGY_RST;
         tracer_q <= TRACER_RST;
         fluid_q  <= FLUID_RST;
      end else begin
         case (state_q)
            IDLE: begin
               // Inputs are sampled only here; later changes are ignored.
               if (|req) begin
                  win_q   <= win_d;
                  op_q    <= req_op[win_d];
                  sel_q   <= req_sel[2*win_d +: 2];
                  amt_q   <= req_amt[8*win_d +: 8];
                  busy_q  <= 1'b1;
                  state_q <= EXEC;
               end
            end
            EXEC: begin
               ok_q  <= ok_d;
               sat_q <= sat_d;
               ack_q <= {{(N-1){1'b0}}, 1'b1} << win_q;
               case (sel_q)
                  2'd0:    energy_q <= lvl_d;
                  2'd1:    tracer_q <= lvl_d[5:0];
                  2'd2:    fluid_q  <= lvl_d[3:0];
                  default: ;
               endcase
               state_q <= RESP;
            end
            RESP: begin
               ack_q   <= '0;
               ok_q    <= 1'b0;
               sat_q   <= 1'b0;
               busy_q  <= 1'b0;
               ptr_q   <= ptr_d;
               state_q <= IDLE;
            end
            default: begin
               ack_q   <= '0;
               ok_q    <= 1'b0;
               sat_q   <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign ack    = ack_q;
   assign ok     = ok_q;
   assign sat    = sat_q;
   assign busy   = busy_q;
   assign energy = energy_q;
   assign tracer = tracer_q;
   assign fluid  = fluid_q;

endmodule

// File: tb/tb_resource_arbiter.sv
// ---------------------------------------------------------------------------
// tb_resource_arbiter
//   Table of single-requester transactions with constant expected results,
//   plus hand-written sequences for round-robin, input-ignore during EXEC and
//   reset mid-transaction. Expected results go onto a scoreboard queue when
//   stimulus is driven; a negedge monitor pops and compares on every ack.
// ---------------------------------------------------------------------------
module tb_resource_arbiter;

   localparam int N = 3;

   logic           clk;
   logic           reset;
   logic [N-1:0]   req;
   logic [N-1:0]   req_op;
   logic [2*N-1:0] req_sel;
   logic [8*N-1:0] req_amt;
   logic [N-1:0]   ack;
   logic           ok;
   logic           sat;
   logic           busy;
   logic [7:0]     energy;
   logic [5:0]     tracer;
   logic [3:0]     fluid;

   resource_arbiter #(.N(N)) dut (
      .clk     (clk),
      .reset   (reset),
      .req     (req),
      .req_op  (req_op),
      .req_sel (req_sel),
      .req_amt (req_amt),
      .ack     (ack),
      .ok      (ok),
      .sat     (sat),
      .busy    (busy),
      .energy  (energy),
      .tracer  (tracer),
      .fluid   (fluid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         idx;
      logic       ok;
      logic       sat;
      logic [7:0] e;
      logic [5:0] t;
      logic [3:0] f;
   } exp_t;

   typedef struct {
      int         idx;
      logic       op;
      logic [1:0] sel;
      logic [7:0] amt;
      logic       ok;
      logic       sat;
      logic [7:0] e;
      logic [5:0] t;
      logic [3:0] f;
   } vec_t;

   exp_t sb[$];
   exp_t mon_e;
   int   nchecks = 0;
   int   nerr    = 0;

   task automatic check(input string name, input int act, input int exp);
      nchecks++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard consumer: every ack must match the oldest pending expectation.
   always @(negedge clk) begin
      if (ack != '0) begin
         if (sb.size() == 0) begin
            check("unexpected_ack", int'(ack), 0);
         end else begin
            mon_e = sb.pop_front();
            check("ack_onehot", int'(ack), 1 << mon_e.idx);
            check("ok",     int'(ok),     int'(mon_e.ok));
            check("sat",    int'(sat),    int'(mon_e.sat));
            check("energy", int'(energy), int'(mon_e.e));
            check("tracer", int'(tracer), int'(mon_e.t));
            check("fluid",  int'(fluid),  int'(mon_e.f));
         end
      end
   end

   task automatic drive(input int i, input logic op, input logic [1:0] sel,
                        input logic [7:0] amt);
      req_op[i]         = op;
      req_sel[2*i +: 2] = sel;
      req_amt[8*i +: 8] = amt;
      req[i]            = 1'b1;
   endtask

   task automatic push(input int idx, input logic o, input logic s,
                       input logic [7:0] e, input logic [5:0] t,
                       input logic [3:0] f);
      exp_t x;
      x.idx = idx; x.ok = o; x.sat = s; x.e = e; x.t = t; x.f = f;
      sb.push_back(x);
   endtask

   // Waits (bounded) for any ack; returns negedges elapsed.
   task automatic wait_ack(output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (ack == '0 && cyc < 12);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req   = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   vec_t vecs[15];
   int   cyc;

   initial begin
      // Single-requester transactions, expected pool levels after each.
      vecs[0]  = '{0, 1'b0, 2'd0, 8'd100, 1'b1, 1'b0, 8'd155, 6'd63, 4'd15};
      vecs[1]  = '{0, 1'b0, 2'd0, 8'd200, 1'b0, 1'b0, 8'd155, 6'd63, 4'd15};
      vecs[2]  = '{1, 1'b0, 2'd1, 8'd60,  1'b1, 1'b0, 8'd155, 6'd3,  4'd15};
      vecs[3]  = '{1, 1'b1, 2'd1, 8'd10,  1'b1, 1'b0, 8'd155, 6'd13, 4'd15};
      vecs[4]  = '{1, 1'b1, 2'd1, 8'd200, 1'b1, 1'b1, 8'd155, 6'd63, 4'd15};
      vecs[5]  = '{2, 1'b0, 2'd3, 8'd5,   1'b0, 1'b0, 8'd155, 6'd63, 4'd15};
      vecs[6]  = '{2, 1'b0, 2'd0, 8'd0,   1'b1, 1'b0, 8'd155, 6'd63, 4'd15};
      vecs[7]  = '{0, 1'b1, 2'd0, 8'd100, 1'b1, 1'b0, 8'd255, 6'd63, 4'd15};
      vecs[8]  = '{2, 1'b0, 2'd2, 8'd15,  1'b1, 1'b0, 8'd255, 6'd63, 4'd0};
      vecs[9]  = '{1, 1'b0, 2'd2, 8'd1,   1'b0, 1'b0, 8'd255, 6'd63, 4'd0};
      vecs[10] = '{2, 1'b1, 2'd2, 8'd16,  1'b1, 1'b1, 8'd255, 6'd63, 4'd15};
      vecs[11] = '{0, 1'b1, 2'd0, 8'd1,   1'b1, 1'b1, 8'd255, 6'd63, 4'd15};
      vecs[12] = '{1, 1'b0, 2'd0, 8'd255, 1'b1, 1'b0, 8'd0,   6'd63, 4'd15};
      vecs[13] = '{0, 1'b1, 2'd3, 8'd9,   1'b0, 1'b0, 8'd0,   6'd63, 4'd15};
      vecs[14] = '{1, 1'b1, 2'd1, 8'd0,   1'b1, 1'b0, 8'd0,   6'd63, 4'd15};

      reset   = 1'b1;
      req     = '0;
      req_op  = '0;
      req_sel = '0;
      req_amt = '0;
      @(negedge clk);
      do_reset();

      // Reset state held across idle cycles.
      repeat (5) begin
         @(negedge clk);
         check("idle_ack",  int'(ack),  0);
         check("idle_busy", int'(busy), 0);
      end
      check("rst_energy", int'(energy), 255);
      check("rst_tracer", int'(tracer), 63);
      check("rst_fluid",  int'(fluid),  15);
      check("rst_ok",     int'(ok),     0);
      check("rst_sat",    int'(sat),    0);

      foreach (vecs[v]) begin
         push(vecs[v].idx, vecs[v].ok, vecs[v].sat, vecs[v].e, vecs[v].t, vecs[v].f);
         drive(vecs[v].idx, vecs[v].op, vecs[v].sel, vecs[v].amt);
         @(negedge clk);
         check("busy_exec", int'(busy), 1);
         wait_ack(cyc);
         check("latency", cyc + 1, 2);
         req = '0;
         @(negedge clk);
         check("busy_idle", int'(busy), 0);
      end

      // Inputs changed during EXEC must be ignored: refill 40 energy from 0.
      push(0, 1'b1, 1'b0, 8'd40, 6'd63, 4'd15);
      drive(0, 1'b1, 2'd0, 8'd40);
      @(negedge clk);
      req_op[0]    = 1'b0;
      req_sel[1:0] = 2'd1;
      req_amt[7:0] = 8'd200;
      wait_ack(cyc);
      check("latency_ignore", cyc + 1, 2);
      req = '0;
      @(negedge clk);

      // Round-robin with all three requesters held, each spending 1 fluid.
      do_reset();
      for (int i = 0; i < N; i++) drive(i, 1'b0, 2'd2, 8'd1);
      for (int k = 0; k < 6; k++) push(k % 3, 1'b1, 1'b0, 8'd255, 6'd63, 4'(14 - k));
      for (int k = 0; k < 6; k++) begin
         wait_ack(cyc);
         check("rr_order",   int'(ack), 1 << (k % 3));
         check("rr_spacing", cyc, (k == 0) ? 2 : 3);
         if (k == 5) req = '0;
      end
      @(negedge clk);
      check("rr_fluid", int'(fluid), 9);

      // Advance pointer to 1, then abort a transaction from requester 1.
      push(0, 1'b1, 1'b0, 8'd250, 6'd63, 4'd9);
      drive(0, 1'b0, 2'd0, 8'd5);
      wait_ack(cyc);
      check("latency_pre_abort", cyc, 2);
      req = '0;
      @(negedge clk);

      drive(1, 1'b0, 2'd0, 8'd50);
      @(negedge clk);
      check("abort_busy_exec", int'(busy), 1);
      reset = 1'b1;
      req   = '0;
      @(negedge clk);
      reset = 1'b0;
      check("abort_ack",    int'(ack),    0);
      check("abort_busy",   int'(busy),   0);
      check("abort_energy", int'(energy), 255);
      check("abort_fluid",  int'(fluid),  15);

      // Pointer back at 0: requester 0 must beat requester 2.
      push(0, 1'b1, 1'b0, 8'd255, 6'd60, 4'd15);
      drive(0, 1'b0, 2'd1, 8'd3);
      drive(2, 1'b0, 2'd2, 8'd1);
      wait_ack(cyc);
      check("ptr_after_reset", int'(ack), 1);
      req = '0;
      repeat (2) @(negedge clk);

      check("sb_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", nerr, nchecks);
      $finish;
   end

endmodule
